// File: rtl/axis_gap_framer.sv
// AXIS packet rebuilder: closes a packet after an idle gap on a raw
// valid/data stream, buffering reconstructed beats in an output FIFO.
module axis_gap_framer #(
  parameter int AXIS_BYTES = 1,
  parameter int GAP_CYCLES = 1,
  parameter int MAX_BEATS  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    sreset,
  input  logic                    axis_i_tvalid,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata,
  output logic                    overflow
);

  localparam int DW = AXIS_BYTES * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam int IW = $clog2(GAP_CYCLES + 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] GAP_END = IW'(GAP_CYCLES - 1);

  typedef enum logic {EMPTY, PENDING} state_t;

  state_t        state;
  logic [DW-1:0] hold;
  logic [IW-1:0] idle_ctr;
  logic [CW-1:0] bcnt;

  logic [DW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf_q;

  logic gap_hit;
  logic max_hit;
  logic push;
  logic push_last;
  logic pop;
  logic full;
  logic wr_en;

  // Decide whether the pending beat leaves this cycle and how it is flagged
  always_comb begin
    gap_hit   = (state == PENDING) && !axis_i_tvalid
                && (idle_ctr == GAP_END);
    max_hit   = (MAX_BEATS != 0) && (int'(bcnt) == MAX_BEATS - 1);
    push      = (state == PENDING) && (axis_i_tvalid || gap_hit);
    push_last = gap_hit || max_hit;
    pop       = axis_o_tvalid && axis_o_tready;
    full      = (count == DEPTH_C);
    wr_en     = push && (!full || pop);
  end

  assign axis_o_tvalid = !sreset && (count != '0);
  assign axis_o_tlast  = axis_o_tvalid && mem[rd_ptr][DW];
  assign axis_o_tdata  = mem[rd_ptr][DW-1:0];
  assign overflow      = ovf_q && !sreset;

  // Holding-register FSM, idle-gap timer and per-packet beat counter
  always_ff @(posedge clk) begin
    if (sreset) begin
      state    <= EMPTY;
      idle_ctr <= '0;
      bcnt     <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (axis_i_tvalid) begin
            hold     <= axis_i_tdata;
            idle_ctr <= '0;
            state    <= PENDING;
          end
        end
        PENDING: begin
          if (axis_i_tvalid) begin
            hold     <= axis_i_tdata;
            idle_ctr <= '0;
          end else if (gap_hit) begin
            state <= EMPTY;
          end else begin
            idle_ctr <= idle_ctr + IW'(1);
          end
        end
      endcase
      // dropped pushes still count toward the packet length
      if (push) begin
        if (push_last)
          bcnt <= '0;
        else if (MAX_BEATS != 0)
          bcnt <= bcnt + CW'(1);
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)
        count <= count + (AW+1)'(1);
      else if (!wr_en && pop)
        count <= count - (AW+1)'(1);
      if (push && full && !pop)
        ovf_q <= 1'b1;
    end
  end

  // FIFO storage; the full-with-pop case rewrites the slot being read out
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {push_last, hold};
  end

endmodule
